rename_regfile: RTL and testbench

Architectural register file with per-register rename tags, sitting between the reorder buffer and dispatch. Each register carries a busy flag and the ROB nick of the youngest in-flight producer. The file accepts nick allocations from the ROB at decode and committed results from the ROB at retire. It answers two combinational source lookups for dispatch with either a ready value or the nick to wait on.

---
 rtl/rename_regfile_if.sv | 50 +++++
 rtl/rename_regfile.sv | 131 +++++++++++++
 tb/tb_rename_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rename_regfile_if.sv
// Bus bundle between the ROB / dispatch stages and the rename register file.
// Carries the rename request, the commit write, the flush strobe, the global
// enable and both source lookups.
interface rename_regfile_if #(
    parameter int DataWidth = 32,
    parameter int NickWidth = 5
);
    logic                 rdy;
    logic                 iclr;

    logic                 iROB_nick_en;
    logic [NickWidth-1:0] iROB_nick;
    logic [4:0]           iROB_nick_regnm;

    logic                 iRF_en;
    logic [4:0]           iRF_rd_regnm;
    logic [DataWidth-1:0] iRF_rd_dt;
    logic [NickWidth-1:0] iRF_rd_nick;

    logic [4:0]           iDP_rs1_regnm;
    logic [4:0]           iDP_rs2_regnm;
    logic                 oDP_rs1_busy;
    logic                 oDP_rs2_busy;
    logic [NickWidth-1:0] oDP_rs1_nick;
    logic [NickWidth-1:0] oDP_rs2_nick;
    logic [DataWidth-1:0] oDP_rs1_dt;
    logic [DataWidth-1:0] oDP_rs2_dt;

    // ROB / dispatch side
    modport master (
        output rdy, iclr,
        output iROB_nick_en, iROB_nick, iROB_nick_regnm,
        output iRF_en, iRF_rd_regnm, iRF_rd_dt, iRF_rd_nick,
        output iDP_rs1_regnm, iDP_rs2_regnm,
        input  oDP_rs1_busy, oDP_rs2_busy,
        input  oDP_rs1_nick, oDP_rs2_nick,
        input  oDP_rs1_dt, oDP_rs2_dt
    );

    // Register file side
    modport slave (
        input  rdy, iclr,
        input  iROB_nick_en, iROB_nick, iROB_nick_regnm,
        input  iRF_en, iRF_rd_regnm, iRF_rd_dt, iRF_rd_nick,
        input  iDP_rs1_regnm, iDP_rs2_regnm,
        output oDP_rs1_busy, oDP_rs2_busy,
        output oDP_rs1_nick, oDP_rs2_nick,
        output oDP_rs1_dt, oDP_rs2_dt
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags.
// Each register holds committed data, a busy flag and the nick of the youngest
// in-flight producer. Dispatch sees either a ready value or the nick to wait on;
// a commit landing this cycle on the awaited producer is forwarded directly.
module rename_regfile #(
    parameter int RegNum    = 32,
    parameter int DataWidth = 32,
    parameter int NickWidth = 5
) (
    input  logic              clk,
    input  logic              rst,
    rename_regfile_if.slave   bus
);

    typedef struct packed {
        logic                 busy;
        logic [NickWidth-1:0] nick;
        logic [DataWidth-1:0] dt;
    } lookup_t;

    logic [RegNum-1:0][DataWidth-1:0] data_r;
    logic [RegNum-1:0]                busy_r;
    logic [RegNum-1:0][NickWidth-1:0] tag_r;

    logic [RegNum-1:0][DataWidth-1:0] data_nxt_s;
    logic [RegNum-1:0]                busy_nxt_s;
    logic [RegNum-1:0][NickWidth-1:0] tag_nxt_s;

    lookup_t rs1_s;
    lookup_t rs2_s;

    // Resolve one source: forward a matching commit, else report the pending
    // producer, else return the stored value.
    function automatic lookup_t lookup_src(
        input logic                 busy,
        input logic [NickWidth-1:0] tag,
        input logic [DataWidth-1:0] data,
        input logic                 commit_hit,
        input logic [NickWidth-1:0] commit_nick,
        input logic [DataWidth-1:0] commit_dt
    );
        lookup_t res;
        if (busy && commit_hit && (commit_nick == tag)) begin
            res.busy = 1'b0;
            res.nick = {NickWidth{1'b0}};
            res.dt   = commit_dt;
        end else if (busy) begin
            res.busy = 1'b1;
            res.nick = tag;
            res.dt   = {DataWidth{1'b0}};
        end else begin
            res.busy = 1'b0;
            res.nick = {NickWidth{1'b0}};
            res.dt   = data;
        end
        return res;
    endfunction

    // Next-state: commit data always lands, a matching commit retires the tag,
    // then flush (or otherwise rename) overrides the busy/tag outcome.
    always_comb begin
        data_nxt_s = data_r;
        busy_nxt_s = busy_r;
        tag_nxt_s  = tag_r;
        data_nxt_s[0] = {DataWidth{1'b0}};
        busy_nxt_s[0] = 1'b0;
        tag_nxt_s[0]  = {NickWidth{1'b0}};
        for (int r = 1; r < RegNum; r++) begin
            if (bus.iRF_en && (bus.iRF_rd_regnm == 5'(r))) begin
                data_nxt_s[r] = bus.iRF_rd_dt;
                if (busy_r[r] && (tag_r[r] == bus.iRF_rd_nick)) begin
                    busy_nxt_s[r] = 1'b0;
                    tag_nxt_s[r]  = {NickWidth{1'b0}};
                end else begin
                    busy_nxt_s[r] = busy_r[r];
                    tag_nxt_s[r]  = tag_r[r];
                end
            end else begin
                data_nxt_s[r] = data_r[r];
            end

            if (bus.iclr) begin
                busy_nxt_s[r] = 1'b0;
                tag_nxt_s[r]  = {NickWidth{1'b0}};
            end else if (bus.iROB_nick_en && (bus.iROB_nick_regnm == 5'(r))) begin
                busy_nxt_s[r] = 1'b1;
                tag_nxt_s[r]  = bus.iROB_nick;
            end else begin
                busy_nxt_s[r] = busy_nxt_s[r];
                tag_nxt_s[r]  = tag_nxt_s[r];
            end
        end
    end

    // State register: async clear, updates only while the pipeline is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r <= {(RegNum*DataWidth){1'b0}};
            busy_r <= {RegNum{1'b0}};
            tag_r  <= {(RegNum*NickWidth){1'b0}};
        end else if (bus.rdy) begin
            data_r <= data_nxt_s;
            busy_r <= busy_nxt_s;
            tag_r  <= tag_nxt_s;
        end else begin
            data_r <= data_r;
            busy_r <= busy_r;
            tag_r  <= tag_r;
        end
    end

    // Source lookups: purely combinational from stored state and the commit port.
    always_comb begin
        rs1_s = lookup_src(busy_r[bus.iDP_rs1_regnm], tag_r[bus.iDP_rs1_regnm],
                           data_r[bus.iDP_rs1_regnm],
                           bus.iRF_en && (bus.iRF_rd_regnm == bus.iDP_rs1_regnm),
                           bus.iRF_rd_nick, bus.iRF_rd_dt);
        rs2_s = lookup_src(busy_r[bus.iDP_rs2_regnm], tag_r[bus.iDP_rs2_regnm],
                           data_r[bus.iDP_rs2_regnm],
                           bus.iRF_en && (bus.iRF_rd_regnm == bus.iDP_rs2_regnm),
                           bus.iRF_rd_nick, bus.iRF_rd_dt);
    end

    assign bus.oDP_rs1_busy = rs1_s.busy;
    assign bus.oDP_rs1_nick = rs1_s.nick;
    assign bus.oDP_rs1_dt   = rs1_s.dt;
    assign bus.oDP_rs2_busy = rs2_s.busy;
    assign bus.oDP_rs2_nick = rs2_s.nick;
    assign bus.oDP_rs2_dt   = rs2_s.dt;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: rename, commit, bypass, flush, x0 and rdy.
module tb_rename_regfile;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rename_regfile_if #(.DataWidth(32), .NickWidth(5)) bus ();

    rename_regfile #(.RegNum(32), .DataWidth(32), .NickWidth(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.iclr = 1'b0;
        bus.iROB_nick_en = 1'b0;
        bus.iROB_nick = 5'd0;
        bus.iROB_nick_regnm = 5'd0;
        bus.iRF_en = 1'b0;
        bus.iRF_rd_regnm = 5'd0;
        bus.iRF_rd_dt = 32'd0;
        bus.iRF_rd_nick = 5'd0;
    endtask

    task automatic rename(input logic [4:0] r, input logic [4:0] n);
        bus.iROB_nick_en = 1'b1;
        bus.iROB_nick_regnm = r;
        bus.iROB_nick = n;
    endtask

    task automatic commit(input logic [4:0] r, input logic [4:0] n, input logic [31:0] d);
        bus.iRF_en = 1'b1;
        bus.iRF_rd_regnm = r;
        bus.iRF_rd_nick = n;
        bus.iRF_rd_dt = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.iDP_rs1_regnm = 5'd0;
        bus.iDP_rs2_regnm = 5'd0;
        idle();
        tick();
        tick();
        #2 rst = 1'b1;
        tick();

        // ---- reset mid-run ----
        commit(5'd5, 5'd0, 32'h1234);
        tick();
        idle();
        bus.iDP_rs1_regnm = 5'd5;
        #1 check("x5_written", bus.oDP_rs1_dt, 64'h1234);
        #1 rst = 1'b0;
        #1 check("reset_async_dt", bus.oDP_rs1_dt, 64'h0);
        tick();
        #2 rst = 1'b1;
        tick();
        check("reset_busy", bus.oDP_rs1_busy, 64'h0);
        check("reset_nick", bus.oDP_rs1_nick, 64'h0);
        check("reset_dt", bus.oDP_rs1_dt, 64'h0);

        // ---- rename then matching commit ----
        rename(5'd3, 5'd7);
        tick();
        idle();
        bus.iDP_rs1_regnm = 5'd3;
        #1 check("x3_busy", bus.oDP_rs1_busy, 64'h1);
        check("x3_nick", bus.oDP_rs1_nick, 64'h7);
        check("x3_dt_while_busy", bus.oDP_rs1_dt, 64'h0);
        commit(5'd3, 5'd7, 32'hDEADBEEF);
        #1 check("x3_bypass_busy", bus.oDP_rs1_busy, 64'h0);
        check("x3_bypass_nick", bus.oDP_rs1_nick, 64'h0);
        check("x3_bypass_dt", bus.oDP_rs1_dt, 64'hDEADBEEF);
        tick();
        idle();
        #1 check("x3_stored_busy", bus.oDP_rs1_busy, 64'h0);
        check("x3_stored_dt", bus.oDP_rs1_dt, 64'hDEADBEEF);

        // ---- stale commit ----
        rename(5'd4, 5'd2);
        tick();
        rename(5'd4, 5'd9);
        tick();
        idle();
        bus.iDP_rs2_regnm = 5'd4;
        commit(5'd4, 5'd2, 32'h11);
        #1 check("x4_stale_nobypass", bus.oDP_rs2_busy, 64'h1);
        tick();
        idle();
        #1 check("x4_stale_busy", bus.oDP_rs2_busy, 64'h1);
        check("x4_stale_nick", bus.oDP_rs2_nick, 64'h9);
        commit(5'd4, 5'd9, 32'h22);
        #1 check("x4_bypass_dt", bus.oDP_rs2_dt, 64'h22);
        tick();
        idle();
        #1 check("x4_final_busy", bus.oDP_rs2_busy, 64'h0);
        check("x4_final_dt", bus.oDP_rs2_dt, 64'h22);

        // ---- flush plus commit ----
        commit(5'd8, 5'd0, 32'h88);
        tick();
        idle();
        rename(5'd6, 5'd4);
        tick();
        rename(5'd8, 5'd5);
        tick();
        idle();
        bus.iDP_rs1_regnm = 5'd6;
        bus.iDP_rs2_regnm = 5'd8;
        #1 check("x8_pre_flush_nick", bus.oDP_rs2_nick, 64'h5);
        bus.iclr = 1'b1;
        commit(5'd6, 5'd4, 32'h77);
        tick();
        idle();
        #1 check("x6_flush_busy", bus.oDP_rs1_busy, 64'h0);
        check("x6_flush_dt", bus.oDP_rs1_dt, 64'h77);
        check("x8_flush_busy", bus.oDP_rs2_busy, 64'h0);
        check("x8_flush_nick", bus.oDP_rs2_nick, 64'h0);
        check("x8_flush_dt", bus.oDP_rs2_dt, 64'h88);

        // ---- same-cycle collisions ----
        commit(5'd10, 5'd0, 32'hA0);
        tick();
        idle();
        bus.iDP_rs1_regnm = 5'd10;
        rename(5'd10, 5'd3);
        #1 check("x10_prerename_busy", bus.oDP_rs1_busy, 64'h0);
        check("x10_prerename_dt", bus.oDP_rs1_dt, 64'hA0);
        tick();
        idle();
        #1 check("x10_nick3", bus.oDP_rs1_nick, 64'h3);
        rename(5'd10, 5'd12);
        commit(5'd10, 5'd3, 32'h55);
        #1 check("x10_collide_bypass_dt", bus.oDP_rs1_dt, 64'h55);
        tick();
        idle();
        #1 check("x10_collide_busy", bus.oDP_rs1_busy, 64'h1);
        check("x10_collide_nick", bus.oDP_rs1_nick, 64'hC);
        bus.iclr = 1'b1;
        tick();
        idle();
        #1 check("x10_collide_data", bus.oDP_rs1_dt, 64'h55);

        // ---- x0 ----
        bus.iDP_rs1_regnm = 5'd0;
        rename(5'd0, 5'd6);
        commit(5'd0, 5'd0, 32'hFF);
        #1 check("x0_incycle_dt", bus.oDP_rs1_dt, 64'h0);
        tick();
        idle();
        #1 check("x0_busy", bus.oDP_rs1_busy, 64'h0);
        check("x0_nick", bus.oDP_rs1_nick, 64'h0);
        check("x0_dt", bus.oDP_rs1_dt, 64'h0);

        // ---- rdy low ----
        bus.iDP_rs2_regnm = 5'd2;
        bus.rdy = 1'b0;
        rename(5'd2, 5'd8);
        tick();
        idle();
        bus.rdy = 1'b1;
        #1 check("x2_rdy_rename_busy", bus.oDP_rs2_busy, 64'h0);
        check("x2_rdy_rename_nick", bus.oDP_rs2_nick, 64'h0);
        rename(5'd2, 5'd8);
        tick();
        idle();
        bus.rdy = 1'b0;
        bus.iclr = 1'b1;
        tick();
        idle();
        #1 check("x2_rdy_flush_nick", bus.oDP_rs2_nick, 64'h8);
        commit(5'd2, 5'd8, 32'h99);
        #1 check("x2_rdy_live_bypass", bus.oDP_rs2_dt, 64'h99);
        tick();
        idle();
        bus.rdy = 1'b1;
        #1 check("x2_rdy_commit_busy", bus.oDP_rs2_busy, 64'h1);
        check("x2_rdy_commit_nick", bus.oDP_rs2_nick, 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
